// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer for the 5-stage RV32I core
//
// Purpose: merges data-memory waits, taken-branch redirects and load-use
// hazards into per-stage register enables and bubble/flush controls.
// Priority, highest first: memory wait, taken branch, load-use, normal.
// Forwarding is untouched by this block.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters).
// When undefined, stall_cnt/flush_cnt are tied to 0 and no counters exist.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   IF_ID_rs1, IF_ID_rs2      source registers of the instruction in ID
//   ID_EX_rd, ID_EX_MemRead   destination / load flag of the instruction in EX
//   branch_taken              branch/jump in EX resolves taken
//   EX_MEM_MemAccess          instruction in MEM is a load or store
//   dmem_ready                data memory completes the access this cycle
//   pc_en .. mem_wb_en        register load enables
//   if_id_flush, id_ex_flush, mem_wb_flush   load a NOP bubble
//   pc_sel_target             PC loads the branch target
//   mem_err                   sticky memory-timeout flag
//   stall_cnt, flush_cnt      performance counters
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             branch_taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             pc_sel_target,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = ($clog2(MEM_TIMEOUT + 1) > 5) ? $clog2(MEM_TIMEOUT + 1) : 5;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ERR = WCNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              mem_wait;
  logic              load_use;
  logic              err_set;

  always_comb begin
    mem_wait = EX_MEM_MemAccess && !dmem_ready;
    load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
               ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel_target = 1'b0;
    state_nxt     = state;
    wcnt_nxt      = '0;
    err_set       = 1'b0;

    if (!rstn) begin
      // Hold every stage as a bubble while in reset.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_wait) begin
      // Freeze the pipe; WB retires a bubble so nothing is written twice.
      // A held branch stays in EX and is taken on the release cycle.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path instructions in IF/ID are squashed; load-use on them is moot.
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      pc_sel_target = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    case (state)
      RUN:     if (mem_wait)  state_nxt = MEMWAIT;
      MEMWAIT: if (!mem_wait) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    // wcnt holds the number of completed wait cycles; the cycle that sees
    // MEM_TIMEOUT-1 is wait cycle MEM_TIMEOUT, so mem_err sets on its edge.
    if (mem_wait) begin
      wcnt_nxt = (wcnt == WCNT_MAX) ? wcnt : wcnt + WCNT_W'(1);
      err_set  = (wcnt >= WCNT_ERR);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)        stall_q <= stall_q + CNT_W'(1);
      if (pc_sel_target) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic [4:0]       IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic             ID_EX_MemRead, branch_taken, EX_MEM_MemAccess, dmem_ready;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, mem_wb_flush, pc_sel_target;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_flush,id_ex_flush,mem_wb_flush,pc_sel_target}
  localparam logic [8:0] C_NORMAL = 9'b11111_000_0;
  localparam logic [8:0] C_BRANCH = 9'b11111_110_1;
  localparam logic [8:0] C_LDUSE  = 9'b00111_010_0;
  localparam logic [8:0] C_MEMW   = 9'b00000_001_0;
  localparam logic [8:0] C_RESET  = 9'b00000_111_0;

  logic [8:0] ctrl;
  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, mem_wb_flush, pc_sel_target};

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemRead(ID_EX_MemRead), .branch_taken(branch_taken),
    .EX_MEM_MemAccess(EX_MEM_MemAccess), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .pc_sel_target(pc_sel_target),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs at the falling edge, settle, then let caller check.
  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mrd, input logic br,
                       input logic acc, input logic rdy);
    @(negedge clk);
    rstn = r; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; ID_EX_rd = rd;
    ID_EX_MemRead = mrd; branch_taken = br; EX_MEM_MemAccess = acc; dmem_ready = rdy;
    #1;
  endtask

  task automatic quiet();
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_cnts(input string tag);
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_stall"}, stall_cnt, exp_stall);
    check({tag, "_flush"}, flush_cnt, exp_flush);
`else
    check({tag, "_stall"}, stall_cnt, 0);
    check({tag, "_flush"}, flush_cnt, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; IF_ID_rs1 = '0; IF_ID_rs2 = '0; ID_EX_rd = '0;
    ID_EX_MemRead = 1'b0; branch_taken = 1'b0; EX_MEM_MemAccess = 1'b0; dmem_ready = 1'b1;

    // Reset: bubbles everywhere, state cleared.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_ctrl", ctrl, C_RESET);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_err", mem_err, 1'b0);
    exp_stall = 0; exp_flush = 0;
    check_cnts("reset");

    // First cycle after reset is normal.
    quiet();
    check("normal0", ctrl, C_NORMAL);

    // Load-use on rs2: one bubble, then normal.
    drive(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lduse_rs2", ctrl, C_LDUSE);
    exp_stall = 1;
    quiet();
    check("lduse_after", ctrl, C_NORMAL);
    check_cnts("lduse");

    // rd=0 never stalls, even when it matches.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lduse_rd0", ctrl, C_NORMAL);
    // Load-use on rs1.
    drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    check("lduse_rs1", ctrl, C_LDUSE);
    exp_stall = 2;
    // Load with non-matching rd.
    drive(1'b1, 5'd7, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    check("load_nomatch", ctrl, C_NORMAL);

    // Taken branch.
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    check("branch", ctrl, C_BRANCH);
    exp_flush = 1;
    quiet();
    check_cnts("branch");

    // Branch and load-use together: branch wins, no stall counted.
    drive(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    check("br_lduse", ctrl, C_BRANCH);
    exp_flush = 2;
    quiet();
    check_cnts("br_lduse");

    // Memory wait of 3 cycles with a branch held in EX.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("memw_br%0d", i), ctrl, C_MEMW);
    end
    exp_stall = 5;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    check("memw_release", ctrl, C_BRANCH);
    exp_flush = 3;
    quiet();
    check("memw_run", ctrl, C_NORMAL);
    check_cnts("memw");
    check("memw_noerr", mem_err, 1'b0);

    // Timeout: 15 wait cycles leave mem_err clear, the 16th sets it.
    for (int i = 0; i < 15; i++)
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    check("to_15", mem_err, 1'b0);
    check("to_ctrl", ctrl, C_MEMW);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    check("to_16", mem_err, 1'b1);
    check("to_release", ctrl, C_NORMAL);
    exp_stall = 21;
    quiet();
    check("to_sticky", mem_err, 1'b1);
    check_cnts("timeout");

    // Reset in the middle of a wait.
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rstwait_ctrl", ctrl, C_RESET);
    quiet();
    check("rstwait_run", ctrl, C_NORMAL);
    check("rstwait_err", mem_err, 1'b0);
    exp_stall = 0; exp_flush = 0;
    check_cnts("rstwait");

    // Wait counter was cleared: 15 fresh wait cycles do not time out.
    for (int i = 0; i < 15; i++)
      drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    quiet();
    check("rstwait_wcnt", mem_err, 1'b0);
    exp_stall = 15;
    check_cnts("rstwait2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
